// File: rtl/wb_uart_pkg.sv
// Shared register map, status/control bit positions and TX FSM encoding for wb_uart_tx.
// WB_UART_TX_PARITY_EN adds the PARITY state to the encoding.
package wb_uart_pkg;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_BAUD   = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int unsigned ST_BUSY_BIT  = 0;
    localparam int unsigned ST_FULL_BIT  = 1;
    localparam int unsigned ST_EMPTY_BIT = 2;
    localparam int unsigned ST_OVF_BIT   = 3;
    localparam int unsigned ST_CNT_LSB   = 8;

    localparam int unsigned CTRL_IRQ_EN_BIT  = 0;
    localparam int unsigned CTRL_PAR_ODD_BIT = 1;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_STOP   = 3'd4
`ifdef WB_UART_TX_PARITY_EN
        , TX_PARITY = 3'd3
`endif
    } tx_state_e;

    // A divisor of 0 behaves as 1; the bit counter runs from period-1 down to 0.
    function automatic logic [15:0] bit_period_m1(input logic [15:0] div);
        return (div == 16'd0) ? 16'd0 : div - 16'd1;
    endfunction

endpackage

// File: rtl/wb_uart_tx_fifo.sv
// Byte-wide synchronous TX FIFO; a push to a full FIFO is accepted when a pop happens in the same cycle.
module wb_uart_tx_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk_i,
    input  logic                   nrst_i,
    input  logic                   push_i,
    input  logic [7:0]             data_i,
    input  logic                   pop_i,
    output logic [7:0]             rd_data_c_o,
    output logic                   full_c_o,
    output logic                   empty_c_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push_c, do_pop_c;

    assign empty_c_o   = (count_q == CW'(0));
    assign full_c_o    = (count_q == CW'(DEPTH));
    assign rd_data_c_o = mem_q[rd_ptr_q];
    assign count_o     = count_q;

    always_comb begin
        do_pop_c  = pop_i & ~empty_c_o;
        do_push_c = push_i & (~full_c_o | do_pop_c);
        wr_ptr_d  = do_push_c ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = do_pop_c ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d   = count_q;
        if (do_push_c && !do_pop_c) begin
            count_d = count_q + CW'(1);
        end else if (do_pop_c && !do_push_c) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push_c) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/wb_uart_tx.sv
// Wishbone B3 classic slave driving a FIFO-buffered 8N1 UART transmitter.
// Defining WB_UART_TX_PARITY_EN inserts a parity bit (CTRL bit1 selects odd).
module wb_uart_tx
    import wb_uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter logic [15:0] BAUD_DIV_RST = 16'd868
) (
    input  logic        clk_i,
    input  logic        nrst_i,
    input  logic [3:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        uart_tx,
    output logic        irq_o
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             ack_q, ack_d, err_q, err_d, ovf_q, ovf_d, irq_q, irq_d, line_q, line_d;
    logic [31:0]      dat_q, dat_d, status_c;
    logic [15:0]      baud_q, baud_d, div_q, div_d, cnt_q, cnt_d;
    logic [1:0]       ctrl_q, ctrl_d;
    logic [7:0]       shift_q, shift_d, rd_data_c;
    logic [2:0]       bit_q, bit_d;
    logic [CNT_W-1:0] fifo_count;
    logic             req_c, bad_c, wr_c, rd_c, push_c, pop_c, load_c, full_c, empty_c;
    logic             unused_c;
    tx_state_e        state_q, state_d;
`ifdef WB_UART_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    assign unused_c = ^{wb_sel_i[3:1], wb_dat_i[31:16]};

    wb_uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i       (clk_i),
        .nrst_i      (nrst_i),
        .push_i      (push_c),
        .data_i      (wb_dat_i[7:0]),
        .pop_i       (pop_c),
        .rd_data_c_o (rd_data_c),
        .full_c_o    (full_c),
        .empty_c_o   (empty_c),
        .count_o     (fifo_count)
    );

    // Bus decode; offsets with nonzero adr[1:0] are reserved.
    always_comb begin
        req_c  = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
        bad_c  = (wb_adr_i[1:0] != 2'b00) | ~wb_sel_i[0];
        wr_c   = req_c & ~bad_c & wb_we_i;
        rd_c   = req_c & ~bad_c & ~wb_we_i;
        push_c = wr_c & (wb_adr_i[3:2] == REG_TXDATA);
    end

    always_comb begin
        status_c                         = '0;
        status_c[ST_BUSY_BIT]            = (state_q != TX_IDLE);
        status_c[ST_FULL_BIT]            = full_c;
        status_c[ST_EMPTY_BIT]           = empty_c;
        status_c[ST_OVF_BIT]             = ovf_q;
        status_c[ST_CNT_LSB +: CNT_W]    = fifo_count;

        ack_d  = req_c & ~bad_c;
        err_d  = req_c & bad_c;
        dat_d  = '0;
        baud_d = baud_q;
        ctrl_d = ctrl_q;
        ovf_d  = ovf_q;
        irq_d  = empty_c & ctrl_q[CTRL_IRQ_EN_BIT];

        if (rd_c) begin
            case (wb_adr_i[3:2])
                REG_STATUS: dat_d = status_c;
                REG_BAUD:   dat_d = 32'(baud_q);
                REG_CTRL:   dat_d = 32'(ctrl_q);
                default:    dat_d = '0;
            endcase
        end
        if (push_c && full_c && !pop_c) begin
            ovf_d = 1'b1;
        end
        if (wr_c) begin
            case (wb_adr_i[3:2])
                REG_STATUS: if (wb_dat_i[ST_OVF_BIT]) ovf_d = 1'b0;
                REG_BAUD:   baud_d = wb_dat_i[15:0];
`ifdef WB_UART_TX_PARITY_EN
                REG_CTRL:   ctrl_d = wb_dat_i[1:0];
`else
                REG_CTRL:   ctrl_d = {1'b0, wb_dat_i[CTRL_IRQ_EN_BIT]};
`endif
                default:    ;
            endcase
        end
    end

    // Transmit FSM; the line register follows the next state so it changes with the state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        load_c  = 1'b0;
        pop_c   = 1'b0;
        line_d  = 1'b1;
`ifdef WB_UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            TX_IDLE: load_c = ~empty_c;
            TX_START: begin
                cnt_d = cnt_q - 16'd1;
                if (cnt_q == 16'd0) begin
                    state_d = TX_DATA;
                    cnt_d   = div_q;
                end
            end
            TX_DATA: begin
                cnt_d = cnt_q - 16'd1;
                if (cnt_q == 16'd0) begin
                    cnt_d = div_q;
                    if (bit_q == 3'd7) begin
`ifdef WB_UART_TX_PARITY_EN
                        state_d = TX_PARITY;
`else
                        state_d = TX_STOP;
`endif
                    end else begin
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + 3'd1;
                    end
                end
            end
`ifdef WB_UART_TX_PARITY_EN
            TX_PARITY: begin
                cnt_d = cnt_q - 16'd1;
                if (cnt_q == 16'd0) begin
                    state_d = TX_STOP;
                    cnt_d   = div_q;
                end
            end
`endif
            TX_STOP: begin
                cnt_d = cnt_q - 16'd1;
                if (cnt_q == 16'd0) begin
                    state_d = TX_IDLE;
                    load_c  = ~empty_c;
                end
            end
            default: state_d = TX_IDLE;
        endcase

        if (load_c) begin
            pop_c   = 1'b1;
            state_d = TX_START;
            shift_d = rd_data_c;
            bit_d   = 3'd0;
            div_d   = bit_period_m1(baud_q);
            cnt_d   = bit_period_m1(baud_q);
`ifdef WB_UART_TX_PARITY_EN
            par_d   = (^rd_data_c) ^ ctrl_q[CTRL_PAR_ODD_BIT];
`endif
        end

        case (state_d)
            TX_START:  line_d = 1'b0;
            TX_DATA:   line_d = shift_d[0];
`ifdef WB_UART_TX_PARITY_EN
            TX_PARITY: line_d = par_d;
`endif
            default:   line_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
            baud_q  <= BAUD_DIV_RST;
            ctrl_q  <= '0;
            ovf_q   <= 1'b0;
            irq_q   <= 1'b0;
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            shift_q <= '0;
            bit_q   <= '0;
            line_q  <= 1'b1;
`ifdef WB_UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
            baud_q  <= baud_d;
            ctrl_q  <= ctrl_d;
            ovf_q   <= ovf_d;
            irq_q   <= irq_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            line_q  <= line_d;
`ifdef WB_UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign wb_dat_o = dat_q;
    assign uart_tx  = line_q;
    assign irq_o    = irq_q;

endmodule
